// File: rtl/ex1_pkg.sv
// rtl/ex1_pkg.sv - shared state encoding and table constants for the preimage scanner
package ex1_pkg;

   localparam int TABLE_SIZE = 8;
   localparam int IDX_W      = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TABLE_SIZE - 1);

endpackage

// File: rtl/ex1_func.sv
// rtl/ex1_func.sv - combinational a,b,c -> x,y function being inverted by the scanner
module ex1_func (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic x,
   output logic y
);

   assign x = (~b & c) | (~a & c) | (a & b & ~c);
   assign y = (~a & ~b) | (~b & ~c) | (a & b);

endmodule

// File: rtl/ex1_preimage.sv
// rtl/ex1_preimage.sv - scans all {a,b,c} once per start and reports those mapping to target
module ex1_preimage
   import ex1_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [1:0]            target,
   output logic                  busy,
   output logic                  hit,
   output logic [2:0]            hit_abc,
   output logic                  done,
   output logic [TABLE_SIZE-1:0] match_mask,
   output logic [3:0]            match_count
);

   state_t           state;
   state_t           state_next;
   logic [1:0]       target_q;
   logic [IDX_W-1:0] idx;
   logic             fx;
   logic             fy;

   ex1_func u_func (
      .a (idx[2]),
      .b (idx[1]),
      .c (idx[0]),
      .x (fx),
      .y (fy)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (start) state_next = ST_SCAN;
         ST_SCAN: if (idx == IDX_LAST) state_next = ST_DONE;
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // Results are only touched by an accepted start or a SCAN hit, so they hold through DONE and IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         target_q    <= 2'b00;
         idx         <= '0;
         match_mask  <= '0;
         match_count <= 4'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  target_q    <= target;
                  idx         <= '0;
                  match_mask  <= '0;
                  match_count <= 4'd0;
               end
            end
            ST_SCAN: begin
               if (hit) begin
                  match_mask[idx] <= 1'b1;
                  match_count     <= match_count + 4'd1;
               end
               if (idx != IDX_LAST) begin
                  idx <= idx + IDX_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign busy    = (state != ST_IDLE);
   assign done    = (state == ST_DONE);
   assign hit     = (state == ST_SCAN) && ({fx, fy} == target_q);
   assign hit_abc = hit ? idx : 3'b000;

endmodule

// File: tb/tb_ex1_preimage.sv
// tb/tb_ex1_preimage.sv - directed and randomized scans against a truth-table reference model
module tb_ex1_preimage;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [1:0] target;
   logic       busy;
   logic       hit;
   logic [2:0] hit_abc;
   logic       done;
   logic [7:0] match_mask;
   logic [3:0] match_count;

   int checks   = 0;
   int failures = 0;

   ex1_preimage dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .target      (target),
      .busy        (busy),
      .hit         (hit),
      .hit_abc     (hit_abc),
      .done        (done),
      .match_mask  (match_mask),
      .match_count (match_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] ref_xy(input int i);
      bit a, b, c, x, y;
      a = i[2];
      b = i[1];
      c = i[0];
      x = (!b && c) || (!a && c) || (a && b && !c);
      y = (!a && !b) || (!b && !c) || (a && b);
      return {x, y};
   endfunction

   function automatic logic [7:0] ref_mask(input logic [1:0] t);
      logic [7:0] m;
      m = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (ref_xy(i) == t) m[i] = 1'b1;
      end
      return m;
   endfunction

   // Called at a negedge with the DUT in IDLE; returns at the negedge of the IDLE cycle after done.
   task automatic run_scan(input logic [1:0] t, input bit disturb,
                           output logic [7:0] mask_o, output logic [3:0] cnt_o);
      logic [7:0] em;
      int         ec;
      em = ref_mask(t);
      ec = $countones(em);
      target = t;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("scan_busy_t%0d_k%0d", t, k), busy, 1);
         chk($sformatf("scan_done_t%0d_k%0d", t, k), done, 0);
         chk($sformatf("scan_hit_t%0d_k%0d", t, k), hit, em[k]);
         chk($sformatf("scan_abc_t%0d_k%0d", t, k), hit_abc, em[k] ? k : 0);
         if (disturb && k == 2) begin
            start  = 1'b1;
            target = ~t;
         end
         if (disturb && k == 4) start = 1'b0;
         @(negedge clk);
      end
      chk($sformatf("done_pulse_t%0d", t), done, 1);
      chk($sformatf("done_busy_t%0d", t), busy, 1);
      chk($sformatf("done_hit_t%0d", t), hit, 0);
      chk($sformatf("done_mask_t%0d", t), match_mask, em);
      chk($sformatf("done_count_t%0d", t), match_count, ec);
      mask_o = match_mask;
      cnt_o  = match_count;
      @(negedge clk);
      chk($sformatf("idle_done_t%0d", t), done, 0);
      chk($sformatf("idle_busy_t%0d", t), busy, 0);
      chk($sformatf("idle_mask_hold_t%0d", t), match_mask, em);
      chk($sformatf("idle_count_hold_t%0d", t), match_count, ec);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_hit"}, hit, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_abc"}, hit_abc, 0);
      chk({tag, "_mask"}, match_mask, 0);
      chk({tag, "_count"}, match_count, 0);
   endtask

   initial begin
      logic [7:0] m;
      logic [3:0] c;
      logic [7:0] acc;
      int         sum;
      logic [1:0] order [4];
      logic [1:0] tmp;
      int         j;

      rst_n  = 1'b0;
      start  = 1'b0;
      target = 2'b00;
      @(negedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);
      chk_all_zero("post_reset_idle");

      // Four targets back to back; each new start lands in the first IDLE cycle after done.
      acc = 8'h00;
      sum = 0;
      run_scan(2'b00, 1'b0, m, c);
      chk("t00_mask_const", m, 8'h04);
      chk("t00_count_const", c, 1);
      chk("disjoint_t00", acc & m, 0); acc |= m; sum += c;
      run_scan(2'b01, 1'b0, m, c);
      chk("t01_mask_const", m, 8'h91);
      chk("t01_count_const", c, 3);
      chk("disjoint_t01", acc & m, 0); acc |= m; sum += c;
      run_scan(2'b10, 1'b0, m, c);
      chk("t10_mask_const", m, 8'h28);
      chk("t10_count_const", c, 2);
      chk("disjoint_t10", acc & m, 0); acc |= m; sum += c;
      run_scan(2'b11, 1'b0, m, c);
      chk("t11_mask_const", m, 8'h42);
      chk("t11_count_const", c, 2);
      chk("disjoint_t11", acc & m, 0); acc |= m; sum += c;
      chk("sum_counts", sum, 8);
      chk("union_masks", acc, 8'hFF);

      // start held high through the DONE cycle must not be accepted at that edge.
      target = 2'b10;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      chk("hold_done_pulse", done, 1);
      start = 1'b1;
      @(negedge clk);
      chk("hold_idle_busy", busy, 0);
      chk("hold_idle_done", done, 0);
      chk("hold_idle_mask", match_mask, 8'h28);
      run_scan(2'b11, 1'b0, m, c);
      chk("hold_rescan_mask", m, 8'h42);

      // Mid-scan start/target changes are ignored.
      run_scan(2'b01, 1'b1, m, c);
      chk("disturb_mask_const", m, 8'h91);
      chk("disturb_idle_after", busy, 0);

      // Reset during scan cycle 4.
      target = 2'b01;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("pre_reset_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk_all_zero("midscan_reset");
      @(negedge clk);
      @(negedge clk);
      chk_all_zero("midscan_reset_held");
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("after_reset_done_%0d", k), done, 0);
         chk($sformatf("after_reset_busy_%0d", k), busy, 0);
      end
      run_scan(2'b01, 1'b0, m, c);
      chk("after_reset_mask", m, 8'h91);

      // Randomized rounds: each round covers all four targets in a shuffled order.
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 4; i++) order[i] = 2'(i);
         for (int i = 3; i > 0; i--) begin
            j = $urandom_range(i, 0);
            tmp      = order[i];
            order[i] = order[j];
            order[j] = tmp;
         end
         acc = 8'h00;
         sum = 0;
         for (int i = 0; i < 4; i++) begin
            run_scan(order[i], 1'($urandom_range(1, 0)), m, c);
            chk($sformatf("rnd%0d_disjoint_%0d", r, i), acc & m, 0);
            acc |= m;
            sum += c;
            repeat ($urandom_range(2, 0)) @(negedge clk);
         end
         chk($sformatf("rnd%0d_sum", r), sum, 8);
         chk($sformatf("rnd%0d_union", r), acc, 8'hFF);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ex1_preimage.md
EX1_PREIMAGE -- requirements
Module: ex1_preimage

Interface
REQ-001 SHALL have clock and reset ports first: clk input 1 (rising-edge system clock); rst_n input 1 (asynchronous, active-low reset).
REQ-002 SHALL have port start input 1: request a scan; sampled only in IDLE.
REQ-003 SHALL have port target input 2: requested output pair {x,y}; latched when start is accepted.
REQ-004 SHALL have port busy output 1: high in SCAN and DONE.
REQ-005 SHALL have port hit output 1: one-cycle pulse per matching input combination.
REQ-006 SHALL have port hit_abc output 3: the {a,b,c} combination that matched; valid only while hit is high.
REQ-007 SHALL have port done output 1: one-cycle pulse when the scan completes.
REQ-008 SHALL have port match_mask output 8: bit i set when {a,b,c}=i maps to the target.
REQ-009 SHALL have port match_count output 4: number of matches, range 0..8.

Function
REQ-010 SHALL evaluate x = ~b&c | ~a&c | a&b&~c and y = ~a&~b | ~b&~c | a&b for each {a,b,c}.
REQ-011 SHALL implement FSM states IDLE, SCAN and DONE.
REQ-012 SHALL, in IDLE with start=1 at a clock edge, latch target, clear idx, match_mask and match_count, and enter SCAN.
REQ-013 SHALL, in SCAN, evaluate idx=0..7 over exactly 8 consecutive cycles, one index per cycle in ascending order.
REQ-014 SHALL, on a match, pulse hit with hit_abc=idx in that same cycle, and set match_mask[idx] and increment match_count at the following edge.
REQ-015 SHALL go from SCAN to DONE after idx=7; done is high for exactly one cycle in DONE, then the FSM returns to IDLE.
REQ-016 SHALL give a fixed latency: start accepted at edge N; SCAN cycles N+1..N+8; done high in cycle N+9; busy high in cycles N+1..N+9.
REQ-017 SHALL hold match_mask and match_count stable from DONE until the next accepted start.
REQ-018 SHALL ignore start while busy; ignore target changes after latching; treat start held high in the DONE cycle as not accepted, with start accepted only on a later edge in IDLE.
REQ-019 SHALL keep idx 3 bits wide, with no wrap-around into a second pass; match_count SHALL be 4 bits wide so that 8 is representable.
REQ-020 SHALL keep hit and hit_abc at 0 outside matching SCAN cycles.

Reset
REQ-021 SHALL, while rst_n=0, immediately force: FSM IDLE; busy, hit, done 0; hit_abc 0; match_mask 0x00; match_count 0; latched target and idx 0.
REQ-022 SHALL abort any scan on reset mid-scan with no done pulse; after release, the block waits in IDLE for a new start.

Structure
REQ-023 SHALL define the state encoding (IDLE=0, SCAN=1, DONE=2) and the constants TABLE_SIZE=8 and IDX_W=3 in the shared package ex1_pkg.
REQ-024 SHALL instantiate exactly one sub-module, ex1_func: the combinational a,b,c -> x,y function, driven by idx.

Verification
REQ-025 SHALL cover: target=2'b00 -> one hit (hit_abc=3'b010); done in cycle N+9; match_mask=0x04; match_count=1.
REQ-026 SHALL cover: target=2'b01 -> hits 000, 100, 111 in scan cycles 1, 5, 8; match_mask=0x91; match_count=3.
REQ-027 SHALL cover: targets 2'b10 and 2'b11 back-to-back -> mask 0x28 count 2 (hits 011, 101), then mask 0x42 count 2 (hits 001, 110); the second start is issued in the first IDLE cycle after done.
REQ-028 SHALL cover: start re-pulsed and target changed mid-scan -> no restart; results match the originally latched target; done pulses exactly once.
REQ-029 SHALL cover: rst_n low during scan cycle 4 -> all outputs 0 immediately, no done pulse; a new start after release produces a correct full scan.
REQ-030 SHALL cover, in every scenario: the sum of match_count over all four targets is 8, and the four match_masks are disjoint.
